// File: rtl/rr_arb2_stream_pkg.sv
// rtl/rr_arb2_stream_pkg.sv - shared FSM encodings and reset constants for the 2-input arbiter
//
// Purpose: state encoding for the packet-lock FSM and the reset value of the
// last-granted source (1 means src0 wins the first contention).
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } state_t;

    localparam logic RST_LAST_GRANT = 1'b1;

endpackage

// File: rtl/rr_arb2_stream_if.sv
// rtl/rr_arb2_stream_if.sv - handshake bundle for the 2-input round-robin stream arbiter
//
// Purpose: groups both input channels, the grant and the registered output channel.
// Ports (signals):
//   in0_valid/in0_data/in0_last/in0_ready  source 0 channel
//   in1_valid/in1_data/in1_last/in1_ready  source 1 channel
//   sel                                     combinational grant (0=src0, 1=src1)
//   out_valid/out_data/out_last/out_src     registered output beat
//   out_ready                               downstream accept
// Modports: slave = arbiter side, master = sources/sink side.
interface rr_arb2_stream_if #(
    parameter int DATA_W = 8
);
    logic              in0_valid;
    logic [DATA_W-1:0] in0_data;
    logic              in0_last;
    logic              in0_ready;
    logic              in1_valid;
    logic [DATA_W-1:0] in1_data;
    logic              in1_last;
    logic              in1_ready;
    logic              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_src;
    logic              out_ready;

    modport slave (
        input  in0_valid, in0_data, in0_last,
        input  in1_valid, in1_data, in1_last,
        input  out_ready,
        output in0_ready, in1_ready, sel,
        output out_valid, out_data, out_last, out_src
    );

    modport master (
        output in0_valid, in0_data, in0_last,
        output in1_valid, in1_data, in1_last,
        output out_ready,
        input  in0_ready, in1_ready, sel,
        input  out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/rr_arb2_stream_mux.sv
// rtl/rr_arb2_stream_mux.sv - combinational 2:1 mux of {last,data}
//
// Purpose: selects one source payload for the arbiter output register.
// Ports:
//   sel_i  select (0=in0_i, 1=in1_i)
//   in0_i  source 0 {last,data}
//   in1_i  source 1 {last,data}
//   out_o  selected {last,data}
module stream_mux2 #(
    parameter int W = 9
) (
    input  logic         sel_i,
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    output logic [W-1:0] out_o
);
    assign out_o = sel_i ? in1_i : in0_i;
endmodule

// File: rtl/rr_arb2_stream.sv
// rtl/rr_arb2_stream.sv - two-input round-robin stream arbiter with packet lock
//
// Purpose: picks a source per packet (round robin at packet boundaries), muxes its
// beat and registers it into a single-entry output stage. One beat per cycle.
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    rr_arb2_stream_if.slave: both input channels, sel, output channel
module rr_arb2_stream
    import arb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_arb2_stream_if.slave   bus
);
    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              out_src_q, out_src_d;

    logic              sel;
    logic              load_en;
    logic              sel_valid;
    logic              accept;
    logic [DATA_W:0]   mux_out;

    stream_mux2 #(.W(DATA_W + 1)) u_mux (
        .sel_i (sel),
        .in0_i ({bus.in0_last, bus.in0_data}),
        .in1_i ({bus.in1_last, bus.in1_data}),
        .out_o (mux_out)
    );

    always_comb begin
        sel          = ~last_grant_q;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_src_d    = out_src_q;

        // The output stage can take a beat when empty or draining this cycle.
        load_en = ~out_valid_q | bus.out_ready;

        unique case (state_q)
            // Exactly one requester gets it outright; both or none fall back to
            // the round-robin pointer so the grant is well defined when idle.
            ST_IDLE:  if (bus.in0_valid ^ bus.in1_valid) sel = bus.in1_valid;
            ST_LOCK0: sel = 1'b0;
            ST_LOCK1: sel = 1'b1;
            default:  state_d = ST_IDLE;
        endcase

        sel_valid = sel ? bus.in1_valid : bus.in0_valid;
        accept    = load_en & sel_valid;

        if (accept) begin
            out_valid_d              = 1'b1;
            {out_last_d, out_data_d} = mux_out;
            out_src_d                = sel;
            if (mux_out[DATA_W]) begin
                // Packet boundary: release the lock and advance fairness.
                state_d      = ST_IDLE;
                last_grant_d = sel;
            end else begin
                state_d = sel ? ST_LOCK1 : ST_LOCK0;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= RST_LAST_GRANT;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_src_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_src_q    <= out_src_d;
        end
    end

    // In a lock the grant equals the holder, so gating by sel alone already
    // keeps the other source out.
    assign bus.in0_ready = load_en & ~sel;
    assign bus.in1_ready = load_en & sel;
    assign bus.sel       = sel;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_rr_arb2_stream.sv
// tb/tb_rr_arb2_stream.sv - self-checking bench for rr_arb2_stream
module tb_rr_arb2_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_arb2_stream_if #(.DATA_W(8)) bus ();

    rr_arb2_stream #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model: who holds the packet lock (-1 none), who last finished
    // a packet, and the contents of the one-entry output stage.
    int         m_lock;
    int         m_lg;
    bit         m_ov;
    logic [7:0] m_od;
    bit         m_ol;
    bit         m_os;
    bit         macc [2];

    logic [8:0] log_q [$];
    int         logc_q [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int m_sel();
        if (m_lock >= 0) return m_lock;
        if (bus.in0_valid && bus.in1_valid) return 1 - m_lg;
        if (bus.in0_valid) return 0;
        if (bus.in1_valid) return 1;
        return 1 - m_lg;
    endfunction

    task automatic m_reset();
        m_lock = -1;
        m_lg   = 1;
        m_ov   = 1'b0;
        m_od   = 8'h00;
        m_ol   = 1'b0;
        m_os   = 1'b0;
    endtask

    // One clock: compare every DUT output against the model at the falling edge,
    // then advance the model across the rising edge.
    task automatic step();
        int         s;
        bit         le;
        bit         v;
        bit         ordy;
        logic [7:0] d;
        bit         l;
        @(negedge clk);
        s    = m_sel();
        ordy = bus.out_ready;
        le   = !m_ov || ordy;
        chk("sel",       32'(bus.sel),       32'(s));
        chk("in0_ready", 32'(bus.in0_ready), 32'(le && s == 0));
        chk("in1_ready", 32'(bus.in1_ready), 32'(le && s == 1));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("out_data",  32'(bus.out_data),  32'(m_od));
        chk("out_last",  32'(bus.out_last),  32'(m_ol));
        chk("out_src",   32'(bus.out_src),   32'(m_os));
        if (bus.out_valid && bus.out_ready) begin
            log_q.push_back({bus.out_src, bus.out_data});
            logc_q.push_back(cyc);
        end
        v = (s == 1) ? bus.in1_valid : bus.in0_valid;
        d = (s == 1) ? bus.in1_data  : bus.in0_data;
        l = (s == 1) ? bus.in1_last  : bus.in0_last;
        macc[0] = 1'b0;
        macc[1] = 1'b0;
        @(posedge clk);
        cyc++;
        if (le && v) begin
            macc[s] = 1'b1;
            m_ov = 1'b1;
            m_od = d;
            m_ol = l;
            m_os = (s == 1);
            if (l) begin
                m_lock = -1;
                m_lg   = s;
            end else begin
                m_lock = s;
            end
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.in0_valid = 1'b0;
        bus.in0_data  = 8'h00;
        bus.in0_last  = 1'b0;
        bus.in1_valid = 1'b0;
        bus.in1_data  = 8'h00;
        bus.in1_last  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_data",  32'(bus.out_data),  32'd0);
        chk("rst out_src",   32'(bus.out_src),   32'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        log_q.delete();
        logc_q.delete();
    endtask

    initial begin
        logic [8:0] exp2 [4];
        logic [8:0] exp3 [4];
        int i0, i1, idx, guard;
        bit done1;
        bit pres [2];

        idle_inputs();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("init out_valid", 32'(bus.out_valid), 32'd0);
        chk("init out_data",  32'(bus.out_data),  32'd0);
        chk("init out_last",  32'(bus.out_last),  32'd0);
        chk("init out_src",   32'(bus.out_src),   32'd0);
        chk("init sel",       32'(bus.sel),       32'd0);

        // 1. reset mid-packet: src1 locked, reset, then contention goes to src0
        bus.in1_valid = 1'b1; bus.in1_last = 1'b0; bus.in1_data = 8'h11;
        step();
        bus.in1_data = 8'h12;
        step();
        chk("t1 out_valid before rst", 32'(bus.out_valid), 32'd1);
        do_reset();
        bus.in0_valid = 1'b1; bus.in0_last = 1'b1; bus.in0_data = 8'h01;
        bus.in1_valid = 1'b1; bus.in1_last = 1'b1; bus.in1_data = 8'h02;
        #1;
        chk("t1 sel after rst",  32'(bus.sel),       32'd0);
        chk("t1 in0_ready",      32'(bus.in0_ready), 32'd1);
        step();
        idle_inputs();
        step();

        // 2. contention with single-beat packets alternates sources
        do_reset();
        i0 = 0; i1 = 0;
        repeat (6) begin
            bus.in0_valid = 1'b1; bus.in0_last = 1'b1; bus.in0_data = 8'hA0 + 8'(i0);
            bus.in1_valid = 1'b1; bus.in1_last = 1'b1; bus.in1_data = 8'hB0 + 8'(i1);
            step();
            if (macc[0]) i0++;
            if (macc[1]) i1++;
        end
        idle_inputs();
        step();
        step();
        exp2 = '{9'h0A0, 9'h1B0, 9'h0A1, 9'h1B1};
        chk("t2 count", 32'(log_q.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++)
            if (k < log_q.size()) chk("t2 beat", 32'(log_q[k]), 32'(exp2[k]));

        // 3. packet lock: src0 3-beat packet ahead of src1
        do_reset();
        idx = 0; done1 = 1'b0; guard = 0;
        while ((idx < 3 || !done1) && guard < 12) begin
            bus.in0_valid = (idx < 3);
            bus.in0_data  = (idx == 0) ? 8'h11 : (idx == 1) ? 8'h22 : 8'h33;
            bus.in0_last  = (idx == 2);
            bus.in1_valid = !done1;
            bus.in1_data  = 8'h99;
            bus.in1_last  = 1'b1;
            #1;
            if (idx < 3) chk("t3 in1_ready held", 32'(bus.in1_ready), 32'd0);
            step();
            if (macc[0]) idx++;
            if (macc[1]) done1 = 1'b1;
            guard++;
        end
        chk("t3 finished", 32'(idx == 3 && done1), 32'd1);
        idle_inputs();
        step();
        step();
        exp3 = '{9'h011, 9'h022, 9'h033, 9'h199};
        chk("t3 count", 32'(log_q.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            if (k < log_q.size()) chk("t3 beat", 32'(log_q[k]), 32'(exp3[k]));

        // 4. backpressure holds the output and blocks both inputs
        do_reset();
        bus.in0_valid = 1'b1; bus.in0_last = 1'b1; bus.in0_data = 8'h5A;
        step();
        bus.out_ready = 1'b0;
        bus.in0_data  = 8'h6B;
        repeat (4) begin
            #1;
            chk("t4 hold data",  32'(bus.out_data),  32'h5A);
            chk("t4 hold valid", 32'(bus.out_valid), 32'd1);
            chk("t4 in0_ready",  32'(bus.in0_ready), 32'd0);
            chk("t4 in1_ready",  32'(bus.in1_ready), 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t4 release in0_ready", 32'(bus.in0_ready), 32'd1);
        step();
        chk("t4 next data",  32'(bus.out_data),  32'h6B);
        chk("t4 next valid", 32'(bus.out_valid), 32'd1);
        idle_inputs();
        step();
        chk("t4 drained", 32'(log_q.size()), 32'd2);

        // 5. idle lock holder keeps the other source out
        do_reset();
        bus.in1_valid = 1'b1; bus.in1_last = 1'b0; bus.in1_data = 8'h71;
        step();
        bus.in1_valid = 1'b0;
        bus.in0_valid = 1'b1; bus.in0_last = 1'b1; bus.in0_data = 8'h0A;
        repeat (3) begin
            #1;
            chk("t5 in0_ready", 32'(bus.in0_ready), 32'd0);
            chk("t5 sel",       32'(bus.sel),       32'd1);
            step();
        end
        bus.in1_valid = 1'b1; bus.in1_last = 1'b1; bus.in1_data = 8'h72;
        step();
        bus.in1_valid = 1'b0;
        #1;
        chk("t5 sel after unlock",  32'(bus.sel),       32'd0);
        chk("t5 in0_ready unlock",  32'(bus.in0_ready), 32'd1);
        step();
        idle_inputs();
        step();

        // 6. throughput: 16 beats from src1 with no bubbles
        do_reset();
        idx = 0; guard = 0;
        while (idx < 16 && guard < 40) begin
            bus.in1_valid = 1'b1;
            bus.in1_data  = 8'h40 + 8'(idx);
            bus.in1_last  = (idx == 15);
            step();
            if (macc[1]) idx++;
            guard++;
        end
        chk("t6 beats sent", 32'(idx), 32'd16);
        idle_inputs();
        step();
        step();
        chk("t6 count", 32'(log_q.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < log_q.size()) begin
                chk("t6 beat", 32'(log_q[k]), 32'({1'b1, 8'h40 + 8'(k)}));
                if (k > 0) chk("t6 gap", 32'(logc_q[k] - logc_q[k-1]), 32'd1);
            end
        end

        // random traffic: sources hold a beat until it is accepted
        do_reset();
        pres[0] = 1'b0;
        pres[1] = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!pres[0] && ($urandom % 10) < 6) begin
                pres[0] = 1'b1;
                bus.in0_data = 8'($urandom);
                bus.in0_last = ($urandom % 3) == 0;
            end
            if (!pres[1] && ($urandom % 10) < 6) begin
                pres[1] = 1'b1;
                bus.in1_data = 8'($urandom);
                bus.in1_last = ($urandom % 3) == 0;
            end
            bus.in0_valid = pres[0];
            bus.in1_valid = pres[1];
            bus.out_ready = ($urandom % 4) != 0;
            step();
            if (macc[0]) pres[0] = 1'b0;
            if (macc[1]) pres[1] = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
